// File: rtl/mul_issue.sv
// mul_issue: tag pipeline, RAW hazard detection and issue counter for a 2-stage multiplier
module mul_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    output logic [31:0] opA,
    output logic [31:0] opB,
    output logic        mul_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        hazard_stall,
    output logic [1:0]  inflight,
    output logic [31:0] mul_count
);
    logic        w_accept;
    logic        w_hit_issue;
    logic        w_hit_s1;
    logic        r_s1_valid;
    logic        r_s2_valid;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s2_rd;
    logic [31:0] r_mul_count;

    // A destination matches decode when it is live, not x0, and named by either source
    function automatic logic f_match(input logic [4:0] r, input logic v, input logic [4:0] a, input logic [4:0] b);
        return v && (r != 5'd0) && ((r == a) || (r == b));
    endfunction

    // Operand gating, stall pass-through, hazard and occupancy are all combinational
    always_comb begin
        w_accept     = issue_valid && !stall_in && !flush;
        opA          = issue_valid ? rs1_data : 32'h0;
        opB          = issue_valid ? rs2_data : 32'h0;
        mul_stall    = stall_in;
        w_hit_issue  = f_match(issue_rd, w_accept, dec_rs1, dec_rs2);
        w_hit_s1     = f_match(r_s1_rd, r_s1_valid, dec_rs1, dec_rs2);
        hazard_stall = dec_valid && (w_hit_issue || w_hit_s1);
        inflight     = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};
        wb_valid     = r_s2_valid;
        wb_rd        = r_s2_rd;
        mul_count    = r_mul_count;
    end

    // s1 tracks the operand register; a flush during a stall kills the held op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rd    <= 5'd0;
        end else if (!stall_in) begin
            r_s1_valid <= w_accept;
            r_s1_rd    <= issue_rd;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end
    end

    // s2 tracks the result register; the older op always retires, so flush never touches it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_rd    <= 5'd0;
        end else if (!stall_in) begin
            r_s2_valid <= r_s1_valid;
            r_s2_rd    <= r_s1_rd;
        end
    end

    // Count accepted issues, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mul_count <= 32'd0;
        else if (w_accept)
            r_mul_count <= r_mul_count + 32'd1;
    end
endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue: directed scenarios with a retirement-order scoreboard for mul_issue
module tb_mul_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        mul_stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        hazard_stall;
    logic [1:0]  inflight;
    logic [31:0] mul_count;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [4:0]  q[$];
    logic [31:0] exp_cnt = 32'd0;

    mul_issue dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .opA(opA), .opB(opB), .mul_stall(mul_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .hazard_stall(hazard_stall),
        .inflight(inflight), .mul_count(mul_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall_in    = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs1_data    = 32'd0;
        rs2_data    = 32'd0;
        dec_valid   = 1'b0;
        dec_rs1     = 5'd0;
        dec_rs2     = 5'd0;
    endtask

    // Advance one clock: push accepted issues, pop/compare each new retirement, track the counter
    task automatic tick();
        logic st;
        st = stall_in;
        if (issue_valid && !stall_in && !flush) begin
            q.push_back(issue_rd);
            exp_cnt++;
        end
        @(posedge clk);
        #1;
        if (!st && wb_valid) begin
            if (q.size() > 0)
                chk("wb_rd_order", 32'(wb_rd), 32'(q.pop_front()));
            else
                chk("wb_spurious", 32'(wb_valid), 32'd0);
        end
        chk("mul_count", mul_count, exp_cnt);
    endtask

    // Assert reset between clock edges, check the cleared state at once, release mid-cycle
    task automatic do_reset();
        #2 rst_n = 1'b0;
        idle();
        q.delete();
        exp_cnt = 32'd0;
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_mul_count", mul_count, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        do_reset();
        // operand gating and stall pass-through
        issue_valid = 1'b1;
        issue_rd    = 5'd2;
        rs1_data    = 32'hDEAD_BEEF;
        rs2_data    = 32'h1234_5678;
        stall_in    = 1'b1;
        #1;
        chk("opA_issue", opA, 32'hDEAD_BEEF);
        chk("opB_issue", opB, 32'h1234_5678);
        chk("mul_stall_hi", 32'(mul_stall), 32'd1);
        tick();
        chk("stalled_issue_inflight", 32'(inflight), 32'd0);
        issue_valid = 1'b0;
        stall_in    = 1'b0;
        #1;
        chk("opA_idle", opA, 32'd0);
        chk("opB_idle", opB, 32'd0);
        chk("mul_stall_lo", 32'(mul_stall), 32'd0);
        tick();
        // back-to-back issue rd=3 then rd=4
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_rd = 5'd4;
        #1;
        chk("b2b_inflight_n1", 32'(inflight), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("b2b_wb_valid_n2", 32'(wb_valid), 32'd1);
        chk("b2b_wb_rd_n2", 32'(wb_rd), 32'd3);
        chk("b2b_inflight_n2", 32'(inflight), 32'd2);
        tick();
        chk("b2b_wb_valid_n3", 32'(wb_valid), 32'd1);
        chk("b2b_wb_rd_n3", 32'(wb_rd), 32'd4);
        chk("b2b_inflight_n3", 32'(inflight), 32'd1);
        tick();
        chk("b2b_wb_valid_n4", 32'(wb_valid), 32'd0);
        chk("b2b_inflight_n4", 32'(inflight), 32'd0);
        // stall hold: rd=5, three stalled cycles
        do_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        tick();
        issue_valid = 1'b0;
        stall_in    = 1'b1;
        repeat (3) begin
            chk("stall_wb_early", 32'(wb_valid), 32'd0);
            tick();
        end
        stall_in = 1'b0;
        chk("stall_wb_n4", 32'(wb_valid), 32'd0);
        tick();
        chk("stall_wb_n5", 32'(wb_valid), 32'd1);
        chk("stall_wb_rd_n5", 32'(wb_rd), 32'd5);
        stall_in = 1'b1;
        tick();
        chk("stall_wb_hold", 32'(wb_valid), 32'd1);
        chk("stall_wb_rd_hold", 32'(wb_rd), 32'd5);
        chk("stall_count", mul_count, 32'd1);
        stall_in = 1'b0;
        tick();
        chk("stall_wb_done", 32'(wb_valid), 32'd0);
        // hazard on rd=7 via rs2
        dec_valid   = 1'b1;
        dec_rs1     = 5'd1;
        dec_rs2     = 5'd7;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        chk("haz_issue", 32'(hazard_stall), 32'd1);
        tick();
        issue_valid = 1'b0;
        #1;
        chk("haz_s1", 32'(hazard_stall), 32'd1);
        tick();
        chk("haz_s2_ignored", 32'(hazard_stall), 32'd0);
        chk("haz_s2_wb", 32'(wb_valid), 32'd1);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        dec_rs1     = 5'd0;
        dec_rs2     = 5'd0;
        #1;
        chk("haz_x0_issue", 32'(hazard_stall), 32'd0);
        tick();
        issue_valid = 1'b0;
        #1;
        chk("haz_x0_s1", 32'(hazard_stall), 32'd0);
        tick();
        stall_in    = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd6;
        dec_rs1     = 5'd6;
        #1;
        chk("haz_unaccepted", 32'(hazard_stall), 32'd0);
        tick();
        idle();
        tick();
        // flush kills rd=9 while rd=8 retires
        do_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        tick();
        issue_rd = 5'd9;
        flush    = 1'b1;
        #1;
        chk("flush_inflight", 32'(inflight), 32'd1);
        tick();
        issue_valid = 1'b0;
        flush       = 1'b0;
        chk("flush_wb_valid", 32'(wb_valid), 32'd1);
        chk("flush_wb_rd", 32'(wb_rd), 32'd8);
        tick();
        chk("flush_no_wb9", 32'(wb_valid), 32'd0);
        chk("flush_count", mul_count, 32'd1);
        tick();
        chk("flush_quiet", 32'(wb_valid), 32'd0);
        // counter wrap
        force dut.r_mul_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_mul_count;
        exp_cnt = 32'hFFFF_FFFF;
        #1;
        chk("wrap_preset", mul_count, 32'hFFFF_FFFF);
        issue_valid = 1'b1;
        issue_rd    = 5'd10;
        tick();
        issue_valid = 1'b0;
        chk("wrap_zero", mul_count, 32'd0);
        tick();
        tick();
        // async reset with two ops in flight
        issue_valid = 1'b1;
        issue_rd    = 5'd11;
        tick();
        issue_rd = 5'd12;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("arst_inflight_pre", 32'(inflight), 32'd2);
        do_reset();
        repeat (3) begin
            tick();
            chk("arst_no_wb", 32'(wb_valid), 32'd0);
        end
        chk("sb_drain", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
